avalon_pio_ext: RTL
===================

# avalon_pio_ext

Parametrised Avalon-MM slave PIO: the successor to the fixed 16-bit output-only hex-digit PIO. It adds a configurable-width output register with atomic set/clear aliases and a synchronised input port. The input port has per-bit edge capture and a maskable level interrupt. It sits on the Nios II data master's Avalon-MM fabric, drives board outputs (hex digits, LEDs), and samples switches/keys.

## Interface
- OUT_WIDTH, 16: output register width, 1..32
- IN_WIDTH, 8: input port width, 1..32
- OUT_RESET, 0: reset value of output register
- EDGE_MODE, 0: capture type; 0 = rising, 1 = falling, 2 = any
- SYNC_STAGES, 2: input synchroniser depth, 2..4
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- address  in  3  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational, zero wait states
- in_port  in  IN_WIDTH  asynchronous board inputs
- out_port  out  OUT_WIDTH  registered outputs
- irq  out  1  level interrupt, active-high

## Operation
- Write strobe: chipselect && !write_n. Writes use writedata[W-1:0]; upper bits are ignored. Unused readdata bits read 0.
- Register map:
  - 0 OUT_DATA, RW: write loads, read returns out_port.
  - 1 IN_DATA, RO: synchronised in_port.
  - 2 IRQ_MASK, RW, IN_WIDTH bits.
  - 3 EDGE_CAP, R/W1C.
  - 4 OUT_SET, WO: out |= wd; reads 0.
  - 5 OUT_CLR, WO: out &= ~wd; reads 0.
  - 6–7 reserved: writes ignored, reads 0.
- Reads have no side effects. readdata reflects the addressed register in the same cycle.
- Input path:
  - SYNC_STAGES flop chain per bit, giving in_sync.
  - One further register holds in_prev.
  - Edge is detected when in_sync != in_prev, qualified by EDGE_MODE.
- Edge capture: a detected edge sets the EDGE_CAP bit, and the bit stays set until software writes 1 to it.
- Simultaneous edge and W1C on the same bit: the bit stays set (the new event wins).
- irq = |(EDGE_CAP & IRQ_MASK), combinational from registers, no glitch path from in_port.
- Arming counter:
  - Edge detection is suppressed until SYNC_STAGES+1 clocks after reset_n deassertion.
  - This prevents a spurious capture when an input is held high through reset.
  - Saturating counter; `armed` flag.

## Timing
- Reset (async assert, sync-safe deassert assumed upstream):
  - out_port = OUT_RESET.
  - IRQ_MASK = 0, EDGE_CAP = 0.
  - Sync chain, in_prev and arming counter = 0.
  - irq = 0.
- Write latency: register updates at the clk edge ending the write cycle; out_port changes 1 cycle after the strobe.
- Input latency: IN_DATA reflects a stable in_port change SYNC_STAGES edges after it is first sampled.
- EDGE_CAP sets 1 edge after IN_DATA changes; irq asserts in that same cycle if masked-in.
- W1C: EDGE_CAP bit clears and irq deasserts 1 cycle after the strobe (absent a coincident edge).
- Mask write: irq follows the new mask 1 cycle after the strobe.
- Reset mid-operation: all state returns to reset values immediately; the arming window restarts.
- Pulses shorter than one clk period may be missed. No pulse stretching.

## Structure
- Package avalon_pio_pkg:
  - register offset constants REG_OUT_DATA..REG_OUT_CLR.
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY.
  - arming counter width function.
- Sub-module pio_edge_sync:
  - per-vector synchroniser, in_prev register and edge-detect qualifier.
  - parameters WIDTH, SYNC_STAGES, EDGE_MODE.
  - outputs in_sync and edge pulse vector.
- Top: address decode, output/mask/capture registers, arming counter, read mux, irq.

## Test plan
- Reset with OUT_RESET=16'h00FF -> out_port=16'h00FF, irq=0, all readable registers as specified. Write 0x1234 to addr 0 -> out_port=0x1234 next cycle, readback 0x1234.
- With out=0x00F0: write 0x000F to addr 4 -> 0x00FF. Then write 0x0030 to addr 5 -> 0x00CF. Reads of addr 4 and 5 return 0.
- EDGE_MODE=0, mask=0x01: in_port[0] 0→1 -> IN_DATA bit0 after 2 edges, EDGE_CAP=0x01 and irq=1 one edge later. Falling edge causes no further change.
- Write 0x01 to addr 3 on the same cycle a new rising edge is detected on bit0 -> bit stays 1, irq stays 1. Clear on a quiet cycle -> irq=0 next cycle.
- in_port=0xFF held through reset -> no EDGE_CAP bits set after release; IN_DATA=0xFF after SYNC_STAGES cycles.
- Assert reset_n low mid-capture (EDGE_CAP=0x05, out=0xABCD) -> all values return to reset immediately; writes to addr 6/7 are ignored and read 0.

Source files
------------

// File: rtl/avalon_pio_pkg.sv
// avalon_pio_pkg
// Shared definitions for the parametrised Avalon-MM PIO: register word
// offsets, edge-capture mode codes and the arming-counter width helper.
package avalon_pio_pkg;

  // Register word offsets (3-bit Avalon word address).
  localparam logic [2:0] REG_OUT_DATA = 3'd0;
  localparam logic [2:0] REG_IN_DATA  = 3'd1;
  localparam logic [2:0] REG_IRQ_MASK = 3'd2;
  localparam logic [2:0] REG_EDGE_CAP = 3'd3;
  localparam logic [2:0] REG_OUT_SET  = 3'd4;
  localparam logic [2:0] REG_OUT_CLR  = 3'd5;

  // Edge-capture qualifier codes.
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // The arming counter saturates at sync_stages+1, so it must hold that value.
  function automatic int arm_cnt_width(input int sync_stages);
    return $clog2(sync_stages + 2);
  endfunction

endpackage

// File: rtl/pio_edge_sync.sv
// pio_edge_sync
// Per-bit synchroniser for asynchronous board inputs, followed by one
// history register and the edge qualifier selected by EDGE_MODE.
//
// Ports:
//   clk        in   clock
//   reset_n    in   asynchronous active-low reset
//   in_async   in   WIDTH raw board inputs
//   in_sync    out  WIDTH synchronised inputs (last chain stage)
//   edge_pulse out  WIDTH one-cycle qualified edge indication per bit
module pio_edge_sync
  import avalon_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_async,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] edge_pulse
);

  // chain[0] is the metastability-catching stage; chain[SYNC_STAGES-1] is safe.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0]                  in_prev;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain   <= '0;
      in_prev <= '0;
    end else begin
      chain   <= {chain[SYNC_STAGES-2:0], in_async};
      in_prev <= chain[SYNC_STAGES-1];
    end
  end

  assign in_sync = chain[SYNC_STAGES-1];

  // NOTE: the default assignment up front keeps this block latch-free for
  // every EDGE_MODE value, including unsupported ones.
  always_comb begin
    edge_pulse = '0;
    case (EDGE_MODE)
      EDGE_RISING:  edge_pulse = in_sync & ~in_prev;
      EDGE_FALLING: edge_pulse = ~in_sync & in_prev;
      EDGE_ANY:     edge_pulse = in_sync ^ in_prev;
      default:      edge_pulse = '0;
    endcase
  end

endmodule

// File: rtl/avalon_pio_ext.sv
// avalon_pio_ext
// Avalon-MM slave PIO: output register with set/clear aliases, synchronised
// input port with per-bit edge capture (W1C) and a maskable level interrupt.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   address[2:0]   word address
//   chipselect     slave select
//   write_n        active-low write strobe
//   writedata[31:0]
//   readdata[31:0] combinational read data, zero wait states
//   in_port        IN_WIDTH asynchronous board inputs
//   out_port       OUT_WIDTH registered outputs
//   irq            active-high level interrupt
module avalon_pio_ext
  import avalon_pio_pkg::*;
#(
  parameter int                   OUT_WIDTH   = 16,
  parameter int                   IN_WIDTH    = 8,
  parameter logic [OUT_WIDTH-1:0] OUT_RESET   = '0,
  parameter int                   EDGE_MODE   = EDGE_RISING,
  parameter int                   SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  input  logic [IN_WIDTH-1:0]  in_port,
  output logic [OUT_WIDTH-1:0] out_port,
  output logic                 irq
);

  localparam int                ARM_W    = arm_cnt_width(SYNC_STAGES);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES + 1);

  logic                 write_strobe;
  logic [OUT_WIDTH-1:0] wdata_out;
  logic [IN_WIDTH-1:0]  wdata_in;

  logic [OUT_WIDTH-1:0] out_reg;
  logic [IN_WIDTH-1:0]  irq_mask;
  logic [IN_WIDTH-1:0]  edge_cap;
  logic [ARM_W-1:0]     arm_cnt;
  logic                 armed;

  logic [IN_WIDTH-1:0]  in_sync;
  logic [IN_WIDTH-1:0]  edge_pulse;
  logic [IN_WIDTH-1:0]  w1c;
  logic [IN_WIDTH-1:0]  capture;

  assign write_strobe = chipselect && !write_n;
  assign wdata_out    = OUT_WIDTH'(writedata);
  assign wdata_in     = IN_WIDTH'(writedata);

  pio_edge_sync #(
    .WIDTH       (IN_WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_MODE   (EDGE_MODE)
  ) u_edge_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_async   (in_port),
    .in_sync    (in_sync),
    .edge_pulse (edge_pulse)
  );

  // Detection stays off until the sync chain and in_prev have both been
  // refilled after reset, so an input held high through reset never looks
  // like a fresh edge.
  assign armed = (arm_cnt == ARM_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt <= '0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg  <= OUT_RESET;
      irq_mask <= '0;
    end else if (write_strobe) begin
      case (address)
        REG_OUT_DATA: out_reg  <= wdata_out;
        REG_OUT_SET:  out_reg  <= out_reg | wdata_out;
        REG_OUT_CLR:  out_reg  <= out_reg & ~wdata_out;
        REG_IRQ_MASK: irq_mask <= wdata_in;
        default:      ;
      endcase
    end
  end

  // Clear is applied before set so a coincident new edge keeps its bit.
  assign w1c     = (write_strobe && address == REG_EDGE_CAP) ? wdata_in : '0;
  assign capture = edge_pulse & {IN_WIDTH{armed}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= '0;
    end else begin
      edge_cap <= (edge_cap & ~w1c) | capture;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      REG_OUT_DATA: readdata = 32'(out_reg);
      REG_IN_DATA:  readdata = 32'(in_sync);
      REG_IRQ_MASK: readdata = 32'(irq_mask);
      REG_EDGE_CAP: readdata = 32'(edge_cap);
      default:      readdata = '0;
    endcase
  end

  assign out_port = out_reg;
  assign irq      = |(edge_cap & irq_mask);

endmodule
